fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding + hazard unit for the in-order RISC-V pipeline. Tracks destination info of
//  in-flight instructions in its own shadow pipeline (ID/EX, then FWD_DEPTH post-EX stages), drives EX

---
 rtl/fwd_hazard_unit.sv | 137 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadows destination info of in-flight instructions and
// drives EX operand bypass selects plus load-use / multicycle-EX stall, bubble and hold.
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned MUL_LAT    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [REG_ADDR_W-1:0]          id_rs1,
  input  logic [REG_ADDR_W-1:0]          id_rs2,
  input  logic                           id_use_rs1,
  input  logic                           id_use_rs2,
  input  logic [REG_ADDR_W-1:0]          id_rd,
  input  logic                           id_reg_write,
  input  logic                           id_mem_read,
  input  logic                           id_multi,
  input  logic                           ex_flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_b,
  output logic                           stall_if_id,
  output logic                           flush_id_ex,
  output logic                           ex_hold
);
  localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  mr;
    logic                  multi;
  } idex_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  mr;
  } stage_t;

  idex_t            idex_q, idex_d;
  stage_t           pipe_q [1:FWD_DEPTH];
  stage_t           pipe_d [1:FWD_DEPTH];
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             out_en_q, out_en_d;

  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic             lu, hold, flush_eff, live;

  function automatic logic src_hit(input stage_t s, input logic [REG_ADDR_W-1:0] r,
                                   input logic use_r);
    return use_r && s.valid && s.we && (s.rd != '0) && (s.rd == r);
  endfunction

  // First match in ascending stage order keeps the youngest producer.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (idex_q.valid) begin
      for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
        if (fwd_a == '0 && src_hit(pipe_q[k], idex_q.rs1, idex_q.use1)) fwd_a = SEL_W'(k);
        if (fwd_b == '0 && src_hit(pipe_q[k], idex_q.rs2, idex_q.use2)) fwd_b = SEL_W'(k);
      end
    end
  end

  // out_en_q keeps every control quiet in the first cycle after reset release,
  // so a stray flush there must not alter the shadow state either.
  always_comb begin
    live      = !reset && out_en_q;
    flush_eff = ex_flush && out_en_q;
    hold      = idex_q.valid && idex_q.multi && (busy_cnt_q != '0);
    lu        = id_valid && idex_q.valid && idex_q.mr && idex_q.we && (idex_q.rd != '0) &&
                ((id_use_rs1 && id_rs1 == idex_q.rd) || (id_use_rs2 && id_rs2 == idex_q.rd));

    fwd_sel_a   = live ? fwd_a : '0;
    fwd_sel_b   = live ? fwd_b : '0;
    stall_if_id = live && (lu || hold) && !flush_eff;
    flush_id_ex = live && (lu || flush_eff) && !hold;
    ex_hold     = live && hold;
  end

  always_comb begin
    idex_d          = idex_q;
    busy_cnt_d      = (busy_cnt_q != '0) ? busy_cnt_q - CNT_W'(1) : busy_cnt_q;
    out_en_d        = 1'b1;
    pipe_d[1].valid = idex_q.valid;
    pipe_d[1].rd    = idex_q.rd;
    pipe_d[1].we    = idex_q.we;
    pipe_d[1].mr    = idex_q.mr;
    for (int unsigned k = 2; k <= FWD_DEPTH; k++) pipe_d[k] = pipe_q[k-1];

    if (hold) begin
      pipe_d[1] = '0;
    end else if (flush_eff || lu) begin
      idex_d = '0;
    end else begin
      idex_d.valid = id_valid;
      idex_d.rs1   = id_rs1;
      idex_d.rs2   = id_rs2;
      idex_d.use1  = id_use_rs1;
      idex_d.use2  = id_use_rs2;
      idex_d.rd    = id_rd;
      idex_d.we    = id_reg_write;
      idex_d.mr    = id_mem_read;
      idex_d.multi = id_multi;
      if (id_valid && id_multi) busy_cnt_d = CNT_W'(MUL_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q     <= '0;
      pipe_q     <= '{default: '0};
      busy_cnt_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      idex_q     <= idex_d;
      pipe_q     <= pipe_d;
      busy_cnt_q <= busy_cnt_d;
      out_en_q   <= out_en_d;
    end
  end

  a_no_flush_in_hold: assert property (@(posedge clk) disable iff (reset)
    !(ex_flush && hold));
  a_no_load_fwd_stage1: assert property (@(posedge clk) disable iff (reset)
    !(pipe_q[1].mr && (fwd_a == SEL_W'(1) || fwd_b == SEL_W'(1))));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazard sequences followed by random
// instruction streams, checked against a queue-based pipeline occupancy model.
module tb_fwd_hazard_unit;
  localparam int unsigned W     = 5;
  localparam int unsigned D     = 2;
  localparam int unsigned L     = 3;
  localparam int unsigned SEL_W = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_multi;
  logic [W-1:0]     id_rs1, id_rs2, id_rd;
  logic             ex_flush;
  logic [SEL_W-1:0] fwd_sel_a, fwd_sel_b;
  logic             stall_if_id, flush_id_ex, ex_hold;

  fwd_hazard_unit #(.REG_ADDR_W(W), .FWD_DEPTH(D), .MUL_LAT(L)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multi(id_multi),
    .ex_flush(ex_flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_if_id(stall_if_id), .flush_id_ex(flush_id_ex), .ex_hold(ex_hold));

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; bit we; int rs1; bit u1; int rs2; bit u2; bit mr; bit mu;
  } ins_t;
  typedef struct {
    int sel_a; int sel_b; bit stall; bit flush; bit hold; int cyc;
  } exp_t;

  exp_t exp_q[$];
  ins_t m_ex;
  ins_t m_post[$];   // index 0 = first post-EX stage
  int   m_ex_cyc;    // cycles the instruction in EX has spent there
  bit   m_fresh;
  int   cyc_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic ins_t mk(bit v, int rd, bit we, int rs1, bit u1, int rs2, bit u2,
                              bit mr, bit mu);
    ins_t i;
    i.v = v; i.rd = rd; i.we = we; i.rs1 = rs1; i.u1 = u1;
    i.rs2 = rs2; i.u2 = u2; i.mr = mr; i.mu = mu;
    return i;
  endfunction

  function automatic void model_reset();
    m_ex = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_post.delete();
    for (int i = 0; i < int'(D); i++) m_post.push_back(m_ex);
    m_ex_cyc = 0;
    m_fresh  = 1;
  endfunction

  function automatic int fwd_src(int r, bit u);
    if (!m_ex.v || !u || r == 0) return 0;
    for (int k = 0; k < int'(D); k++)
      if (m_post[k].v && m_post[k].we && m_post[k].rd == r) return k + 1;
    return 0;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int   t;
    t     = int'($urandom_range(0, 9));
    i.v   = $urandom_range(0, 7) != 0;
    i.rd  = int'($urandom_range(0, 3));
    i.rs1 = int'($urandom_range(0, 3));
    i.rs2 = int'($urandom_range(0, 3));
    i.u1  = $urandom_range(0, 3) != 0;
    i.u2  = $urandom_range(0, 1) != 0;
    i.mr  = t < 2;
    i.mu  = t == 2;
    i.we  = i.mr || i.mu || ($urandom_range(0, 3) != 0);
    return i;
  endfunction

  // One clock cycle: drive ID fields, record expected outputs, advance the model.
  task automatic step(input ins_t id, input bit fl_req, input bit rst, output bit stalled);
    exp_t e;
    bit   hold, lu, fl;
    @(posedge clk);
    #1;
    hold = m_ex.v && m_ex.mu && (m_ex_cyc < int'(L));
    fl   = fl_req && !hold && !m_fresh && !rst;
    reset        = rst;
    id_valid     = id.v;
    id_rd        = W'(id.rd);
    id_reg_write = id.we;
    id_rs1       = W'(id.rs1);
    id_use_rs1   = id.u1;
    id_rs2       = W'(id.rs2);
    id_use_rs2   = id.u2;
    id_mem_read  = id.mr;
    id_multi     = id.mu;
    ex_flush     = fl;
    lu = id.v && m_ex.v && m_ex.mr && m_ex.we && m_ex.rd != 0 &&
         ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
    e.cyc = cyc_n;
    if (rst || m_fresh) begin
      e.sel_a = 0; e.sel_b = 0; e.stall = 0; e.flush = 0; e.hold = 0;
    end else begin
      e.sel_a = fwd_src(m_ex.rs1, m_ex.u1);
      e.sel_b = fwd_src(m_ex.rs2, m_ex.u2);
      e.stall = (lu || hold) && !fl;
      e.flush = (lu || fl) && !hold;
      e.hold  = hold;
    end
    exp_q.push_back(e);
    stalled = e.stall;
    cyc_n++;
    if (rst) begin
      model_reset();
    end else begin
      if (hold) begin
        m_post.push_front(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_ex_cyc++;
      end else begin
        m_post.push_front(m_ex);
        if (fl || lu) m_ex = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        else m_ex = id;
        m_ex_cyc = 1;
      end
      void'(m_post.pop_back());
      m_fresh = 0;
    end
  endtask

  // Present an instruction and keep re-presenting it while the front end is stalled.
  task automatic send(input ins_t i, input bit fl);
    bit st;
    int n;
    n = 0;
    step(i, fl, 0, st);
    while (st && n < 40) begin
      step(i, 0, 0, st);
      n++;
    end
  endtask

  task automatic chk(input string name, input int c, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_sel_a",   e.cyc, int'(fwd_sel_a),   e.sel_a);
        chk("fwd_sel_b",   e.cyc, int'(fwd_sel_b),   e.sel_b);
        chk("stall_if_id", e.cyc, int'(stall_if_id), int'(e.stall));
        chk("flush_id_ex", e.cyc, int'(flush_id_ex), int'(e.flush));
        chk("ex_hold",     e.cyc, int'(ex_hold),     int'(e.hold));
      end
    end
  end

  initial begin
    ins_t nop, i1, i2, i3;
    bit   st;
    reset = 1'b1; id_valid = 0; id_rd = '0; id_reg_write = 0; id_rs1 = '0; id_use_rs1 = 0;
    id_rs2 = '0; id_use_rs2 = 0; id_mem_read = 0; id_multi = 0; ex_flush = 0;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    step(nop, 0, 1, st);
    step(nop, 0, 1, st);
    send(nop, 0);

    // Producer/consumer distance 1, 2 and 3 on rs1.
    i1 = mk(1, 5, 1, 1, 1, 2, 1, 0, 0);
    i2 = mk(1, 6, 1, 5, 1, 0, 0, 0, 0);
    send(i1, 0); send(i2, 0); repeat (3) send(nop, 0);
    send(i1, 0); send(nop, 0); send(i2, 0); repeat (3) send(nop, 0);
    send(i1, 0); send(nop, 0); send(nop, 0); send(i2, 0); repeat (3) send(nop, 0);

    // Two producers of x5: the younger one wins on rs2.
    send(i1, 0); send(mk(1, 5, 1, 3, 1, 4, 1, 0, 0), 0);
    send(mk(1, 8, 1, 0, 0, 5, 1, 0, 0), 0); repeat (3) send(nop, 0);

    // x0 is never forwarded.
    send(mk(1, 0, 1, 1, 1, 2, 1, 0, 0), 0); send(mk(1, 8, 1, 0, 1, 0, 1, 0, 0), 0);
    repeat (3) send(nop, 0);

    // Load-use: one stall, then forward from stage 2.
    send(mk(1, 7, 1, 1, 1, 0, 0, 1, 0), 0); send(mk(1, 8, 1, 1, 1, 7, 1, 0, 0), 0);
    repeat (3) send(nop, 0);

    // Multicycle op followed by a dependent, then a reset while the hold is active.
    i3 = mk(1, 9, 1, 1, 1, 2, 1, 0, 1);
    send(i3, 0); send(mk(1, 10, 1, 9, 1, 0, 0, 0, 0), 0); repeat (3) send(nop, 0);
    send(i3, 0);
    step(mk(1, 10, 1, 9, 1, 0, 0, 0, 0), 0, 0, st);
    step(nop, 0, 1, st);
    repeat (4) send(nop, 0);

    // Taken branch coinciding with a load-use pattern: flush only, no stall.
    send(mk(1, 7, 1, 1, 1, 0, 0, 1, 0), 0);
    step(mk(1, 8, 1, 1, 1, 7, 1, 0, 0), 1, 0, st);
    repeat (3) send(nop, 0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) step(rnd_ins(), 0, 1, st);
      else send(rnd_ins(), $urandom_range(0, 9) == 0);
    end

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
